// File: rtl/cva6_wrapper_clint_if.sv
// Request/grant register bus between the AXI-to-register adapter and the CLINT.
// The master drives req/we/addr/wdata/be and receives gnt plus a one-cycle-later
// response (rvalid/rdata/err). addr is a byte offset inside the CLINT region.
interface cva6_wrapper_clint_if #(
  parameter int unsigned AddrWidth = 20
) ();
  logic                 req;
  logic                 we;
  logic [AddrWidth-1:0] addr;
  logic [63:0]          wdata;
  logic [7:0]           be;
  logic                 gnt;
  logic                 rvalid;
  logic [63:0]          rdata;
  logic                 err;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/cva6_wrapper_clint.sv
// Core-local interruptor: 64-bit mtime, per-hart mtimecmp and msip, timer and
// software interrupt lines.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   rtc_i        asynchronous real-time tick; mtime advances once per rising edge
//   bus          register slave (req/gnt, one-cycle response, err on unmapped word)
//   timer_irq_o  per-hart registered (mtime >= mtimecmp)
//   ipi_o        per-hart msip bit
module cva6_wrapper_clint #(
  parameter int unsigned NrHarts   = 1,
  parameter int unsigned AddrWidth = 20
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rtc_i,
  cva6_wrapper_clint_if.slave  bus,
  output logic [NrHarts-1:0]   timer_irq_o,
  output logic [NrHarts-1:0]   ipi_o
);

  // 64-bit word indices (byte offset >> 3)
  localparam int unsigned CmpWord   = 32'h800;   // 0x4000
  localparam int unsigned MtimeWord = 32'h17FF;  // 0xBFF8

  logic [2:0]         rtc_sync_q;
  logic               tick;
  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        cmp_q [NrHarts];
  logic [63:0]        cmp_d [NrHarts];
  logic [NrHarts-1:0] msip_q, msip_d;
  logic [NrHarts-1:0] irq_q;
  logic               rvalid_q;
  logic [63:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [31:0]        word;
  logic               wr;

  function automatic logic [63:0] byte_merge(logic [63:0] cur, logic [63:0] wval,
                                             logic [7:0] be);
    logic [63:0] res;
    res = cur;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) res[8*i +: 8] = wval[8*i +: 8];
    end
    return res;
  endfunction

  // rtc_sync_q[1:0] synchronize, rtc_sync_q[2] is the edge-detect delay
  assign tick = rtc_sync_q[1] & ~rtc_sync_q[2];
  assign word = 32'(bus.addr) >> 3;
  assign wr   = bus.req & bus.we;

  assign bus.gnt    = bus.req;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;
  assign timer_irq_o = irq_q;
  assign ipi_o       = msip_q;

  // Read data is taken from current register values, so a read on an update
  // cycle returns the pre-update value.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    msip_d  = msip_q;
    cmp_d   = cmp_q;

    if (word == MtimeWord) begin
      err_d   = 1'b0;
      rdata_d = mtime_q;
      // Unwritten bytes keep the (possibly incremented) value
      if (wr) mtime_d = byte_merge(mtime_d, bus.wdata, bus.be);
    end

    for (int unsigned h = 0; h < NrHarts; h++) begin
      // Hart h lives in bit 0 of the 32-bit lane (h % 2) of word h / 2
      if (word == h / 2) begin
        err_d   = 1'b0;
        rdata_d = rdata_d | (64'(msip_q[h]) << (32 * (h % 2)));
        if ((h % 2) == 0) begin
          if (wr && bus.be[0]) msip_d[h] = bus.wdata[0];
        end else begin
          if (wr && bus.be[4]) msip_d[h] = bus.wdata[32];
        end
      end
      if (word == CmpWord + h) begin
        err_d   = 1'b0;
        rdata_d = cmp_q[h];
        if (wr) cmp_d[h] = byte_merge(cmp_q[h], bus.wdata, bus.be);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rtc_sync_q <= '0;
      mtime_q    <= '0;
      for (int unsigned h = 0; h < NrHarts; h++) cmp_q[h] <= '1;
      msip_q     <= '0;
      irq_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      rtc_sync_q <= {rtc_sync_q[1:0], rtc_i};
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      msip_q     <= msip_d;
      for (int unsigned h = 0; h < NrHarts; h++) irq_q[h] <= (mtime_q >= cmp_q[h]);
      rvalid_q   <= bus.req;
      if (bus.req) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_cva6_wrapper_clint.sv
module tb_cva6_wrapper_clint;
  localparam int unsigned NrHarts   = 1;
  localparam int unsigned AddrWidth = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rtc = 1'b0;
  logic [NrHarts-1:0] timer_irq;
  logic [NrHarts-1:0] ipi;

  cva6_wrapper_clint_if #(.AddrWidth(AddrWidth)) bus ();

  cva6_wrapper_clint #(
    .NrHarts  (NrHarts),
    .AddrWidth(AddrWidth)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rtc_i      (rtc),
    .bus        (bus),
    .timer_irq_o(timer_irq),
    .ipi_o      (ipi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [63:0]        m_mtime;
  logic [63:0]        m_cmp [NrHarts];
  logic [NrHarts-1:0] m_msip;
  logic               r1, r2, r3;  // rtc as seen at the last three clock edges
  logic               e_rvalid;
  logic [63:0]        e_rdata;
  logic               e_err;
  logic [NrHarts-1:0] e_irq;
  bit                 model_on = 0;

  function automatic logic [63:0] apply_be(logic [63:0] cur, logic [63:0] w, logic [7:0] be);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) if (be[i]) mask = mask | (64'hFF << (8 * i));
    return (cur & ~mask) | (w & mask);
  endfunction

  function automatic logic msip_bit(int unsigned idx);
    if (idx < NrHarts) return m_msip[idx];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    logic        tk;
    logic [31:0] off;
    int unsigned a;
    logic [63:0] nxt;
    if (rst) begin
      m_mtime = '0;
      for (int h = 0; h < NrHarts; h++) m_cmp[h] = '1;
      m_msip = '0;
      r1 = 0; r2 = 0; r3 = 0;
      e_rvalid = 0; e_rdata = '0; e_err = 0; e_irq = '0;
      model_on = 1;
    end else begin
      // a rising rtc level seen two edges ago (after being low three ago) ticks now
      tk = r2 & ~r3;
      r3 = r2; r2 = r1; r1 = rtc;
      for (int h = 0; h < NrHarts; h++) e_irq[h] = (m_mtime >= m_cmp[h]);
      nxt = tk ? m_mtime + 64'd1 : m_mtime;
      e_rvalid = bus.req;
      if (bus.req) begin
        off = 32'(bus.addr) & ~32'h7;
        e_err = 1; e_rdata = '0;
        if (off == 32'hBFF8) begin
          e_err = 0; e_rdata = m_mtime;
          if (bus.we) nxt = apply_be(nxt, bus.wdata, bus.be);
        end else if (off >= 32'h4000 && off < 32'h4000 + 8 * NrHarts) begin
          a = (off - 32'h4000) / 8;
          e_err = 0; e_rdata = m_cmp[a];
          if (bus.we) m_cmp[a] = apply_be(m_cmp[a], bus.wdata, bus.be);
        end else if (off / 4 < NrHarts) begin
          a = off / 4;
          e_err = 0;
          e_rdata = {31'b0, msip_bit(a + 1), 31'b0, msip_bit(a)};
          if (bus.we && bus.be[0]) m_msip[a] = bus.wdata[0];
          if (bus.we && bus.be[4] && a + 1 < NrHarts) m_msip[a + 1] = bus.wdata[32];
        end
      end
      m_mtime = nxt;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_on) begin
      check("cyc_rvalid", bus.rvalid, e_rvalid);
      if (e_rvalid) begin
        check("cyc_rdata", bus.rdata, e_rdata);
        check("cyc_err", bus.err, e_err);
      end
      check("cyc_irq", timer_irq, e_irq);
      check("cyc_ipi", ipi, m_msip);
    end
  end

  // ---------------- rtc generator ----------------
  bit rtc_auto = 0;
  int rtc_cnt = 0;
  always @(negedge clk) begin
    if (rtc_auto) begin
      if (rtc_cnt == 0) begin
        rtc = ~rtc;
        rtc_cnt = $urandom_range(2, 4);
      end else begin
        rtc_cnt--;
      end
    end
  end

  // ---------------- stimulus tasks (called at a negedge) ----------------
  task automatic txn(input logic w, input logic [19:0] a, input logic [63:0] d,
                     input logic [7:0] b, output logic [63:0] rd, output logic er,
                     output logic rv);
    bus.req = 1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
    @(negedge clk);
    rd = bus.rdata; er = bus.err; rv = bus.rvalid;
    bus.req = 0; bus.we = 0;
  endtask

  task automatic rd_chk(input string n, input logic [19:0] a, input logic [63:0] exp,
                        input logic exp_err);
    logic [63:0] rd;
    logic        er, rv;
    txn(1'b0, a, 64'd0, 8'h00, rd, er, rv);
    check({n, "_rvalid"}, rv, 1);
    check({n, "_rdata"}, rd, exp);
    check({n, "_err"}, er, exp_err);
  endtask

  task automatic wr(input logic [19:0] a, input logic [63:0] d, input logic [7:0] b);
    logic [63:0] rd;
    logic        er, rv;
    txn(1'b1, a, d, b, rd, er, rv);
  endtask

  task automatic rtc_pulse();
    rtc = 1; repeat (3) @(negedge clk);
    rtc = 0; repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [63:0] rd, prev, d;
    logic        er, rv;
    logic [19:0] a;
    bus.req = 0; bus.we = 0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    repeat (3) @(negedge clk);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_err", bus.err, 0);
    check("rst_irq", timer_irq, 0);
    check("rst_ipi", ipi, 0);
    rst = 0;
    @(negedge clk);

    rd_chk("cmp0_reset", 20'h04000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    rd_chk("mtime_reset", 20'h0BFF8, 64'd0, 1'b0);
    check("irq_idle", timer_irq, 0);

    // timer interrupt
    wr(20'h04000, 64'd5, 8'hFF);
    repeat (5) rtc_pulse();
    check("irq_at_5", timer_irq[0], 1);
    rd_chk("mtime_5", 20'h0BFF8, 64'd5, 1'b0);
    wr(20'h04000, 64'd100, 8'hFF);
    check("irq_hold_1cyc", timer_irq[0], 1);
    @(negedge clk);
    check("irq_fall_2cyc", timer_irq[0], 0);

    // software interrupt
    wr(20'h00000, 64'h1, 8'h0F);
    check("ipi_set", ipi[0], 1);
    rd_chk("msip_rd", 20'h00000, 64'h1, 1'b0);
    wr(20'h00000, 64'hFFFF_FFFE, 8'h0F);
    check("ipi_clr", ipi[0], 0);

    // mtime wrap
    wr(20'h0BFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    rtc_pulse();
    rd_chk("mtime_wrap", 20'h0BFF8, 64'd0, 1'b0);

    // partial write on a tick cycle: byte 0 from data, rest from 0x11
    wr(20'h0BFF8, 64'h10, 8'hFF);
    rtc = 1;
    @(negedge clk);
    @(negedge clk);
    wr(20'h0BFF8, 64'h42, 8'h01);
    rd_chk("mtime_tick_wr", 20'h0BFF8, 64'h42, 1'b0);
    rtc = 0;
    repeat (3) @(negedge clk);

    // unmapped words
    rd_chk("unmap_4008", 20'h04008, 64'd0, 1'b1);
    rd_chk("unmap_8000", 20'h08000, 64'd0, 1'b1);
    rd_chk("unmap_bff0", 20'h0BFF0, 64'd0, 1'b1);
    wr(20'h04008, 64'd0, 8'hFF);
    rd_chk("cmp0_kept", 20'h04000, 64'd100, 1'b0);
    wr(20'h0BFF8, 64'd123, 8'h00);
    rd_chk("be0_noop", 20'h0BFF8, 64'h42, 1'b0);

    // randomized traffic, checked each cycle by the model
    rtc_auto = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
      end else begin
        case ($urandom_range(0, 7))
          0: a = 20'h00000;
          1: a = 20'h00008;
          2, 3: a = 20'h04000;
          4: a = 20'h04008;
          5: a = 20'h0BFF8;
          6: a = 20'h0BFF0;
          default: a = 20'($urandom);
        endcase
        a[2:0] = 3'($urandom);
        if ($urandom_range(0, 1) == 0) d = {$urandom, $urandom};
        else d = 64'($urandom_range(0, 300));
        txn(1'($urandom), a, d, 8'($urandom), rd, er, rv);
      end
    end

    // back-to-back mtime reads
    txn(1'b0, 20'h0BFF8, 64'd0, 8'h00, prev, er, rv);
    for (int i = 0; i < 200; i++) begin
      txn(1'b0, 20'h0BFF8, 64'd0, 8'h00, rd, er, rv);
      check("b2b_rvalid", rv, 1);
      check("b2b_step_le1", ((rd - prev) > 64'd1) ? 64'd1 : 64'd0, 64'd0);
      prev = rd;
    end

    // reset mid-stream
    rtc_auto = 0;
    @(negedge clk);
    rtc = 0;
    repeat (4) @(negedge clk);
    bus.req = 1; bus.we = 0; bus.addr = 20'h0BFF8;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_drops_resp", bus.rvalid, 0);
    @(negedge clk);
    rst = 0; bus.req = 0;
    @(negedge clk);
    check("no_resp_after_rst", bus.rvalid, 0);
    rd_chk("mtime_after_rst", 20'h0BFF8, 64'd0, 1'b0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
